// File: rtl/stream_mavg_if.sv
// Handshake bundle for one AXI-Stream-style sample channel.
interface stream_mavg_if #(
    parameter int unsigned DATA_WIDTH = 16
) ();
    logic [DATA_WIDTH-1:0] tdata;
    logic                  tvalid;
    logic                  tready;

    modport master (output tdata, output tvalid, input tready);
    modport slave  (input tdata, input tvalid, output tready);
endinterface

// File: rtl/stream_mavg.sv
// Boxcar moving-average filter: running sum over a circular history buffer,
// averaging length 2^L selectable up to 2^LOG2_MAX_LEN.
module stream_mavg #(
    parameter int unsigned DATA_WIDTH   = 16,
    parameter int unsigned LOG2_MAX_LEN = 8
) (
    input  logic                clk,
    input  logic                resetn,
    input  logic [7:0]          log2_len,
    stream_mavg_if.slave        stream_i,
    stream_mavg_if.master       stream_o
);
    localparam int unsigned Depth = 1 << LOG2_MAX_LEN;
    localparam int unsigned AddrW = LOG2_MAX_LEN;
    localparam int unsigned AccW  = DATA_WIDTH + LOG2_MAX_LEN;

    typedef enum logic {StClear, StRun} state_e;

    state_e                 state_q, state_d;
    logic [7:0]             len_q, len_d, len_req;
    logic [AddrW-1:0]       wp_q, wp_d, clr_cnt_q, clr_cnt_d;
    logic signed [AccW-1:0] acc_q, acc_d, sum;
    logic [DATA_WIDTH-1:0]  tdata_q, tdata_d;
    logic                   tvalid_q, tvalid_d;

    logic [DATA_WIDTH-1:0]  hist_q [Depth];
    logic                   hist_we;
    logic [AddrW-1:0]       hist_waddr;
    logic [DATA_WIDTH-1:0]  hist_wdata;

    logic [AddrW-1:0]       offset, rd_addr;
    logic [DATA_WIDTH-1:0]  old_sample;
    logic                   out_free, in_hs;

    assign len_req = (log2_len > 8'(LOG2_MAX_LEN)) ? 8'(LOG2_MAX_LEN) : log2_len;

    // Full-depth window wraps onto the slot about to be overwritten.
    assign offset     = (len_q == 8'(LOG2_MAX_LEN)) ? '0 : (AddrW'(1) << len_q);
    assign rd_addr    = wp_q - offset;
    assign old_sample = hist_q[rd_addr];

    assign sum = acc_q
               + {{LOG2_MAX_LEN{stream_i.tdata[DATA_WIDTH-1]}}, stream_i.tdata}
               - {{LOG2_MAX_LEN{old_sample[DATA_WIDTH-1]}}, old_sample};

    assign out_free        = !tvalid_q || stream_o.tready;
    assign stream_i.tready = (state_q == StRun) && out_free && (len_req == len_q);
    assign in_hs           = stream_i.tvalid && stream_i.tready;

    assign stream_o.tdata  = tdata_q;
    assign stream_o.tvalid = tvalid_q;

    always_comb begin
        state_d    = state_q;
        len_d      = len_q;
        wp_d       = wp_q;
        clr_cnt_d  = clr_cnt_q;
        acc_d      = acc_q;
        tdata_d    = tdata_q;
        tvalid_d   = tvalid_q;
        hist_we    = 1'b0;
        hist_waddr = wp_q;
        hist_wdata = stream_i.tdata;

        if (tvalid_q && stream_o.tready) begin
            tvalid_d = 1'b0;
        end

        case (state_q)
            StClear: begin
                hist_we    = 1'b1;
                hist_waddr = clr_cnt_q;
                hist_wdata = '0;
                clr_cnt_d  = clr_cnt_q + 1'b1;
                acc_d      = '0;
                wp_d       = '0;
                if (clr_cnt_q == AddrW'(Depth - 1)) begin
                    state_d = StRun;
                end
            end
            StRun: begin
                if (len_req != len_q) begin
                    len_d     = len_req;
                    clr_cnt_d = '0;
                    state_d   = StClear;
                end else if (in_hs) begin
                    hist_we  = 1'b1;
                    wp_d     = wp_q + 1'b1;
                    acc_d    = sum;
                    tdata_d  = DATA_WIDTH'(sum >>> len_q);
                    tvalid_d = 1'b1;
                end
            end
            default: state_d = StClear;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q   <= StClear;
            len_q     <= '0;
            wp_q      <= '0;
            clr_cnt_q <= '0;
            acc_q     <= '0;
            tdata_q   <= '0;
            tvalid_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            len_q     <= len_d;
            wp_q      <= wp_d;
            clr_cnt_q <= clr_cnt_d;
            acc_q     <= acc_d;
            tdata_q   <= tdata_d;
            tvalid_q  <= tvalid_d;
        end
    end

    // History has no reset; CLEAR defines its contents.
    always_ff @(posedge clk) begin
        if (hist_we) begin
            hist_q[hist_waddr] <= hist_wdata;
        end
    end
endmodule

// File: tb/tb_stream_mavg.sv
// Bench for stream_mavg: directed vector table, ramp/length-change sequences,
// and randomized traffic checked against a windowed-mean reference model.
module tb_stream_mavg;
    localparam int unsigned DW = 16;
    localparam int unsigned LM = 3;
    localparam int unsigned D  = 8;

    logic       clk = 1'b0;
    logic       resetn = 1'b0;
    logic [7:0] log2_len = 8'd0;

    always #5 clk = ~clk;

    stream_mavg_if #(.DATA_WIDTH(DW)) s_in ();
    stream_mavg_if #(.DATA_WIDTH(DW)) s_out ();

    stream_mavg #(.DATA_WIDTH(DW), .LOG2_MAX_LEN(LM)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .log2_len (log2_len),
        .stream_i (s_in),
        .stream_o (s_out)
    );

    int n_cmp = 0;
    int n_err = 0;

    int            win[$];
    logic [DW-1:0] exp_q[$];
    int unsigned   m_len;
    bit            prev_stall;
    logic [DW-1:0] prev_data;
    bit            last_in_hs;

    typedef struct {
        bit         rst;
        logic [7:0] l;
        int         x;
        int         exp;
    } vec_t;

    vec_t tbl[$];

    function automatic int unsigned clampl(input logic [7:0] l);
        return (l > 8'(LM)) ? LM : int'(l);
    endfunction

    // Mean of the last 2^m_len samples since the last clear, zeros before that.
    function automatic logic [DW-1:0] model_exp();
        longint s = 0;
        int n = 1 << m_len;
        int first = (win.size() > n) ? win.size() - n : 0;
        for (int i = first; i < win.size(); i++) s += win[i];
        s = s >>> m_len;
        return DW'(s);
    endfunction

    task automatic check(input string name, input logic signed [63:0] act,
                         input logic signed [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic step(input bit v, input logic [DW-1:0] x, input bit r, input logic [7:0] l);
        @(negedge clk);
        if (prev_stall) begin
            check("hold_valid", s_out.tvalid, 1);
            check("hold_data", s_out.tdata, prev_data);
        end
        check("valid_vs_model", s_out.tvalid, (exp_q.size() != 0) ? 1 : 0);
        if (clampl(l) != m_len) begin
            win.delete();
            m_len = clampl(l);
        end
        log2_len     = l;
        s_in.tvalid  = v;
        s_in.tdata   = x;
        s_out.tready = r;
        #1;
        if (s_out.tvalid && !r) check("stall_blocks_input", s_in.tready, 0);
        last_in_hs = v && s_in.tready;
        if (s_out.tvalid && r) begin
            if (exp_q.size() == 0) check("unexpected_output", 1, 0);
            else check("model_data", $signed(s_out.tdata), $signed(exp_q.pop_front()));
        end
        if (last_in_hs) begin
            win.push_back(int'($signed(x)));
            if (win.size() > D) void'(win.pop_front());
            exp_q.push_back(model_exp());
        end
        prev_stall = s_out.tvalid && !r;
        prev_data  = s_out.tdata;
    endtask

    task automatic do_reset(input logic [7:0] l, input bit check_cnt);
        int cnt;
        @(negedge clk);
        resetn       = 1'b0;
        log2_len     = l;
        s_in.tvalid  = 1'b0;
        s_in.tdata   = '0;
        s_out.tready = 1'b1;
        exp_q.delete();
        win.delete();
        m_len      = clampl(l);
        prev_stall = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_tvalid", s_out.tvalid, 0);
        check("rst_tready", s_in.tready, 0);
        check("rst_tdata", s_out.tdata, 0);
        resetn = 1'b1;
        cnt = 0;
        while (!s_in.tready && cnt < 64) begin
            @(negedge clk);
            cnt++;
        end
        if (!s_in.tready) check("ready_timeout", 0, 1);
        if (check_cnt) check("clear_cycles", cnt, D);
    endtask

    task automatic send_check(input logic [DW-1:0] x, input int exp, input logic [7:0] l,
                              input string name);
        int t = 0;
        do begin
            step(1'b1, x, 1'b1, l);
            t++;
        end while (!last_in_hs && t < 40);
        if (!last_in_hs) check({name, "_accept_timeout"}, 0, 1);
        @(posedge clk);
        #1;
        check({name, "_valid"}, s_out.tvalid, 1);
        check(name, $signed(s_out.tdata), exp);
    endtask

    initial begin
        s_in.tvalid  = 1'b0;
        s_in.tdata   = '0;
        s_out.tready = 1'b1;

        // Reset with length 0: CLEAR lasts exactly D cycles.
        do_reset(8'd0, 1'b1);

        tbl.push_back(vec_t'{1'b1, 8'd2, 100, 25});
        tbl.push_back(vec_t'{1'b0, 8'd2, 100, 50});
        tbl.push_back(vec_t'{1'b0, 8'd2, 100, 75});
        tbl.push_back(vec_t'{1'b0, 8'd2, 100, 100});
        tbl.push_back(vec_t'{1'b0, 8'd2, 100, 100});
        tbl.push_back(vec_t'{1'b1, 8'd1, -1, -1});
        tbl.push_back(vec_t'{1'b0, 8'd1, -1, -1});
        tbl.push_back(vec_t'{1'b1, 8'd1, 3, 1});
        tbl.push_back(vec_t'{1'b1, 8'd0, 5, 5});
        tbl.push_back(vec_t'{1'b0, 8'd0, -7, -7});
        tbl.push_back(vec_t'{1'b0, 8'd0, 32767, 32767});
        tbl.push_back(vec_t'{1'b0, 8'd0, -32768, -32768});
        tbl.push_back(vec_t'{1'b1, 8'd9, 8, 1});
        tbl.push_back(vec_t'{1'b0, 8'd9, -16, -1});
        tbl.push_back(vec_t'{1'b0, 8'd9, -1, -2});

        foreach (tbl[i]) begin
            if (tbl[i].rst) do_reset(tbl[i].l, clampl(tbl[i].l) == 0);
            send_check(DW'(tbl[i].x), tbl[i].exp, tbl[i].l, $sformatf("vec%0d", i));
        end

        // Full-depth ramp exercises pointer wrap-around.
        do_reset(8'd3, 1'b0);
        for (int k = 1; k <= 20; k++) begin
            send_check(DW'(k), (k >= 8) ? k - 4 : (k * (k + 1) / 2) / 8, 8'd3,
                       $sformatf("ramp%0d", k));
        end

        // Random traffic with random backpressure.
        do_reset(8'd2, 1'b0);
        repeat (200) begin
            step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0, 8'd2);
        end

        // Length change 2 -> 3 while an output is pending.
        begin
            int t = 0;
            do begin
                step(1'b1, DW'($urandom), 1'b1, 8'd2);
                t++;
            end while (!last_in_hs && t < 40);
            if (!last_in_hs) check("lenchg_accept_timeout", 0, 1);
        end
        step(1'b1, DW'(123), 1'b0, 8'd3);
        check("lenchg_pending_kept", s_out.tvalid, 1);
        check("lenchg_rdy", s_in.tready, 0);
        for (int i = 0; i < 8; i++) begin
            step(1'b1, DW'(55), i >= 3, 8'd3);
            check("clear_rdy", s_in.tready, 0);
        end
        step(1'b1, DW'(40), 1'b1, 8'd3);
        check("rdy_after_clear", s_in.tready, 1);
        @(posedge clk);
        #1;
        check("restart_zero_hist", $signed(s_out.tdata), 5);

        // log2_len = 9 clamps to 3: no further clear, same averaging.
        repeat (150) begin
            step($urandom_range(0, 3) != 0, DW'($urandom), $urandom_range(0, 2) != 0, 8'd9);
        end
        step(1'b0, '0, 1'b1, 8'd9);
        step(1'b0, '0, 1'b1, 8'd9);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/stream_mavg.md
# stream_mavg

Boxcar moving-average filter for AXI-Stream-style sample streams, placed directly upstream of the stream decimator as its anti-alias stage. Each accepted input sample produces one output sample: the mean of the last N inputs, where N = 2^log2_len is a power of two. Averaging uses a running sum over a circular history buffer, so cost per sample is constant regardless of N.

## Interface
- DATA_WIDTH, 16, sample width; signed two's complement in and out
- LOG2_MAX_LEN, 8, history depth D = 2^LOG2_MAX_LEN; maximum averaging length
- clk  in  1  clock; all logic on rising edge
- resetn  in  1  asynchronous, active-low reset
- log2_len  in  8  requested log2 of averaging length; values > LOG2_MAX_LEN clamp to LOG2_MAX_LEN
- stream_i_tdata  in  DATA_WIDTH  input sample
- stream_i_tvalid  in  1  input valid
- stream_i_tready  out  1  input ready
- stream_o_tdata  out  DATA_WIDTH  averaged sample
- stream_o_tvalid  out  1  output valid
- stream_o_tready  in  1  output ready

## Operation
- State machine: CLEAR, RUN. Reset enters CLEAR.
- Registers: len_q (clamped length in use, L), wp (write pointer, LOG2_MAX_LEN bits, wraps mod D), acc (signed, DATA_WIDTH+LOG2_MAX_LEN bits), clr_cnt, output register.
- CLEAR: writes zero to history address clr_cnt each cycle, clr_cnt 0..D-1; acc <= 0, wp <= 0; after writing D-1, next state RUN. stream_i_tready = 0 throughout.
- RUN: stream_i_tready = (!stream_o_tvalid || stream_o_tready) && (clamp(log2_len) == len_q).
- On input handshake (tvalid && tready) in RUN with sample x:
  - old = hist[(wp - 2^L) mod D], read before the write of this cycle (for L = LOG2_MAX_LEN this is hist[wp] itself)
  - hist[wp] <= x; wp <= wp + 1
  - sum = acc + x - old (sign-extended, full width, no overflow possible); acc <= sum
  - stream_o_tdata <= sum >>> L (arithmetic shift, truncation toward minus infinity), low DATA_WIDTH bits; stream_o_tvalid <= 1
- Output handshake without new input: stream_o_tvalid <= 0; tdata holds.
- Length change: in RUN, if clamp(log2_len) != len_q at a rising edge, len_q <= clamp(log2_len), clr_cnt <= 0, state <= CLEAR. No input accepted that cycle. A pending output (stream_o_tvalid = 1) is kept and delivered normally during CLEAR.
- First outputs after CLEAR average over zero history (ramp-up), by design.
- log2_len = 0: output equals input (pass-through with one cycle latency).

## Timing
- Reset values: stream_o_tvalid 0, stream_o_tdata 0, stream_i_tready 0, state CLEAR, len_q 0, wp 0, acc 0, clr_cnt 0.
- After resetn deasserts, CLEAR lasts exactly D cycles; stream_i_tready may first be 1 in cycle D+1 (first sample accepted on edge D+1 at the earliest). len_q captures clamp(log2_len) at the first edge in RUN via the length-change rule if it differs from 0, costing another D cycles.
- Latency: sample accepted on edge k appears on stream_o_tdata/tvalid after edge k, i.e. one cycle.
- Throughput: one sample per cycle with stream_o_tready held high.
- Output register holds data/valid stable while stream_o_tvalid && !stream_o_tready (AXI rule); no input accepted in that condition.
- resetn assertion mid-operation: all registers return to reset values immediately; history contents are undefined until the following CLEAR completes.

## Test plan
- Reset, LOG2_MAX_LEN=3, log2_len=0: stream_i_tready stays 0 for 8 cycles after release, then 1; tvalid 0 throughout reset.
- log2_len=2, constant input 100 with o_tready=1: outputs 25, 50, 75, 100, 100, ... one cycle after each input.
- log2_len=1, input -1 then -1: outputs -1 (=-1>>>1 truncation), -1; input 3 after clear: output 1.
- Backpressure: hold stream_o_tready=0 after one output; stream_i_tready drops, tdata/tvalid stable; releasing ready resumes with no sample lost or duplicated (compare against golden model over 200 random samples with random ready).
- Wrap-around, LOG2_MAX_LEN=3, log2_len=3 (N=D): ramp 1..20 -> output k>=8 equals floor(sum(k-7..k)/8), e.g. sample 20 -> 16.
- Length change mid-stream 2->3 with a pending output: pending output delivered, tready 0 for 8 cycles, next outputs restart from zero history; log2_len=9 behaves as 3.
